// File: rtl/chip_trig_capture.sv
// rtl/chip_trig_capture.sv - lane-select threshold trigger with pre-trigger capture and word-by-word record dump
module chip_trig_capture #(
    parameter int N_CH  = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 64,
    parameter int PRE   = 16
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] sm_data,
    input  logic               sm_vld,
    input  logic [3:0]         cfg_path_sel,
    input  logic [DW-1:0]      cfg_chip_th,
    input  logic               cfg_mode,
    input  logic               cfg_arm,
    output logic [DW-1:0]      tx_data,
    output logic               tx_vld,
    input  logic               tx_done,
    output logic               busy,
    output logic [15:0]        trig_cnt,
    output logic [15:0]        ovf_cnt
);

    localparam int AW       = $clog2(DEPTH);
    localparam int POST_LEN = DEPTH - PRE - 1;
    localparam logic [AW:0]   PRE_V  = (AW+1)'(PRE);
    localparam logic [AW:0]   POST_V = (AW+1)'(POST_LEN);
    localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_ARM, S_POST, S_DUMP, S_HOLD} state_t;

    state_t state, next_state;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata;

    logic          fresh;          // first cycle out of reset: cfg not yet latched
    logic [3:0]    sel_q, sel_eff;
    logic [DW-1:0] th_q, th_eff;
    logic [DW-1:0] cur, prev;
    logic          prev_valid;
    logic [AW:0]   pre_cnt, post_cnt;
    logic [AW-1:0] wr_ptr, rd_ptr, word_cnt;
    logic          dump_first, ld, pending;

    logic trig, post_last, done_ok, last_done, rd_go, enter_arm, enter_dump, wr_en;

    // Lane mux on the effective selection; out-of-range indices fall back to lane 0
    always_comb begin
        sel_eff = fresh ? cfg_path_sel : sel_q;
        th_eff  = fresh ? cfg_chip_th  : th_q;
        cur     = sm_data[DW-1:0];
        for (int k = 0; k < N_CH; k++) begin
            if (sel_eff == 4'(k)) cur = sm_data[k*DW +: DW];
        end
    end

    assign trig       = (state == S_ARM) && sm_vld && (pre_cnt == PRE_V) && prev_valid &&
                        ($signed(prev) < $signed(th_eff)) && ($signed(cur) >= $signed(th_eff));
    assign post_last  = (state == S_POST) && sm_vld && (post_cnt == (AW+1)'(1));
    assign done_ok    = (state == S_DUMP) && tx_done && pending;
    assign last_done  = done_ok && (word_cnt == LAST_W);
    assign rd_go      = (state == S_DUMP) && (dump_first || (done_ok && !last_done));
    assign enter_arm  = (next_state == S_ARM)  && (state != S_ARM);
    assign enter_dump = (next_state == S_DUMP) && (state != S_DUMP);
    assign wr_en      = sm_vld && ((state == S_ARM) || (state == S_POST));

    // State register
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) state <= S_ARM;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_ARM:  if (trig)      next_state = (POST_LEN == 0) ? S_DUMP : S_POST;
            S_POST: if (post_last) next_state = S_DUMP;
            S_DUMP: if (last_done) next_state = cfg_mode ? S_ARM : S_HOLD;
            S_HOLD: if (cfg_arm)   next_state = S_ARM;
            default:               next_state = S_ARM;
        endcase
    end

    // Sample RAM: write port from the lane mux, registered read port for the dump
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem[wr_ptr] <= cur;
        if (rd_go) rdata <= mem[rd_ptr];
    end

    // Capture datapath, dump sequencer and statistics counters
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fresh      <= 1'b1;
            sel_q      <= '0;
            th_q       <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_cnt   <= '0;
            dump_first <= 1'b0;
            ld         <= 1'b0;
            pending    <= 1'b0;
            tx_data    <= '0;
            tx_vld     <= 1'b0;
            busy       <= 1'b0;
            trig_cnt   <= '0;
            ovf_cnt    <= '0;
        end else begin
            fresh <= 1'b0;
            if (fresh || enter_arm) begin
                sel_q <= cfg_path_sel;
                th_q  <= cfg_chip_th;
            end
            if (enter_arm) begin
                pre_cnt    <= '0;
                prev_valid <= 1'b0;
            end
            if (state == S_ARM && sm_vld) begin
                wr_ptr     <= wr_ptr + AW'(1);
                prev       <= cur;
                prev_valid <= 1'b1;
                if (pre_cnt != PRE_V) pre_cnt <= pre_cnt + (AW+1)'(1);
                if (trig) begin
                    // Dump starts PRE words before the trigger sample's address
                    rd_ptr   <= wr_ptr - AW'(PRE);
                    post_cnt <= POST_V;
                    trig_cnt <= trig_cnt + 16'd1;
                end
            end
            if (state == S_POST && sm_vld) begin
                wr_ptr   <= wr_ptr + AW'(1);
                post_cnt <= post_cnt - (AW+1)'(1);
            end
            dump_first <= enter_dump;
            if (enter_dump) word_cnt <= '0;
            if (rd_go) rd_ptr <= rd_ptr + AW'(1);
            ld     <= rd_go;
            tx_vld <= ld;
            if (done_ok) begin
                pending  <= 1'b0;
                word_cnt <= word_cnt + AW'(1);
            end
            if (ld) begin
                tx_data <= rdata;
                pending <= 1'b1;
            end
            if (state == S_DUMP && sm_vld && !last_done && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
            busy <= (next_state != S_ARM);
        end
    end

endmodule
